// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter on uart_rxd_out.
// Bytes pushed over valid/ready are sent LSB first, CLKS_PER_BIT sysclk cycles per bit.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 32,
    parameter int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  sysclk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  uart_rxd_out,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic [CNT_W-1:0]      fifo_count
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_next;
    logic                  push;
    logic                  pop;
    logic                  avail;
    logic                  avail_q;

    state_t                state;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shreg;

    assign push = s_valid && s_ready;

    // The FSM sees occupancy one cycle late (no bypass); the live count guards a stale flag.
    assign avail = avail_q && (fifo_count != '0);

    always_comb begin
        pop = 1'b0;
        if (avail) begin
            if (state == IDLE) begin
                pop = 1'b1;
            end else if (state == STOP && baud_cnt == BAUD_LAST) begin
                pop = 1'b1;
            end
        end
    end

    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = fifo_count - CNT_W'(1);
        end
    end

    always_ff @(posedge sysclk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge sysclk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            s_ready    <= 1'b0;
            avail_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= count_next;
            s_ready    <= (count_next != CNT_FULL);
            avail_q    <= (fifo_count != '0);
        end
    end

    // Transmit FSM: the line level for each bit is registered on the edge that enters it.
    always_ff @(posedge sysclk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            uart_rxd_out <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (pop) begin
                        shreg        <= mem[rd_ptr];
                        state        <= START;
                        uart_rxd_out <= 1'b0;
                        tx_busy      <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt     <= '0;
                        bit_idx      <= '0;
                        state        <= DATA;
                        uart_rxd_out <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            state        <= STOP;
                            uart_rxd_out <= 1'b1;
                        end else begin
                            bit_idx      <= bit_idx + BIT_W'(1);
                            uart_rxd_out <= shreg[bit_idx + BIT_W'(1)];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    tx_done <= (baud_cnt == BAUD_PRE);
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shreg        <= mem[rd_ptr];
                            state        <= START;
                            uart_rxd_out <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    state        <= IDLE;
                    uart_rxd_out <= 1'b1;
                    tx_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// Bench for uart_tx_fifo: a 4-clock/bit instance covers framing, FIFO full/wrap and reset,
// a default-rate instance checks real bit timing; a line decoder recovers every frame.
module tb_uart_tx_fifo;
    localparam int CPB_A = 4;
    localparam int CPB_B = 1250;
    localparam int DEPTH = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [7:0] data;
        bit         ok;
        longint     start_cyc;
        real        start_t;
    } frame_t;

    logic          sysclk  = 1'b0;
    logic          resetn  = 1'b1;
    logic [7:0]    a_data  = '0;
    logic [7:0]    b_data  = '0;
    logic          a_valid = 1'b0;
    logic          b_valid = 1'b0;
    logic          a_ready, b_ready, a_line, b_line, a_busy, b_busy, a_done, b_done;
    logic [CW-1:0] a_count, b_count;

    longint cyc      = 0;
    int     checks   = 0;
    int     failures = 0;
    int     peak_a   = 0;
    int     starts_a = 0;
    int     starts_b = 0;
    frame_t rxq_a[$];
    frame_t rxq_b[$];
    longint done_a[$];
    longint done_b[$];

    uart_tx_fifo #(.CLKS_PER_BIT(CPB_A), .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut_a (
        .sysclk(sysclk), .resetn(resetn), .s_data(a_data), .s_valid(a_valid),
        .s_ready(a_ready), .uart_rxd_out(a_line), .tx_busy(a_busy), .tx_done(a_done),
        .fifo_count(a_count)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(CPB_B), .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut_b (
        .sysclk(sysclk), .resetn(resetn), .s_data(b_data), .s_valid(b_valid),
        .s_ready(b_ready), .uart_rxd_out(b_line), .tx_busy(b_busy), .tx_done(b_done),
        .fifo_count(b_count)
    );

    always #1 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    always @(negedge sysclk) begin
        if (a_done === 1'b1) done_a.push_back(cyc);
        if (b_done === 1'b1) done_b.push_back(cyc);
    end

    function automatic logic lineOf(input int inst);
        return (inst == 0) ? a_line : b_line;
    endfunction

    function automatic logic readyOf(input int inst);
        return (inst == 0) ? a_ready : b_ready;
    endfunction

    function automatic int rxCount(input int inst);
        return (inst == 0) ? rxq_a.size() : rxq_b.size();
    endfunction

    function automatic frame_t getFrame(input int inst, input int idx);
        frame_t f;
        f.data = 'x; f.ok = 1'b0; f.start_cyc = -1; f.start_t = 0.0;
        if (inst == 0 && idx < rxq_a.size()) f = rxq_a[idx];
        if (inst == 1 && idx < rxq_b.size()) f = rxq_b[idx];
        return f;
    endfunction

    // Line decoder: every cycle of every bit must hold the level seen on its first cycle.
    task automatic runMonitor(input int inst, input int cpb);
        forever begin
            @(negedge sysclk);
            if (resetn === 1'b1 && lineOf(inst) === 1'b0) begin
                frame_t   f;
                logic [9:0] bits;
                bit       aborted;
                f.start_cyc = cyc; f.start_t = $realtime; f.ok = 1'b1;
                bits = '0; aborted = 1'b0;
                if (inst == 0) starts_a++; else starts_b++;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int c = 0; c < cpb && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge sysclk);
                        if (resetn !== 1'b1) aborted = 1'b1;
                        else if (c == 0) bits[b] = lineOf(inst);
                        else if (lineOf(inst) !== bits[b]) f.ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) f.ok = 1'b0;
                    f.data = bits[8:1];
                    if (inst == 0) rxq_a.push_back(f); else rxq_b.push_back(f);
                end
            end
        end
    endtask

    initial runMonitor(0, CPB_A);
    initial runMonitor(1, CPB_B);

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(negedge sysclk);
        if (int'(a_count) > peak_a) peak_a = int'(a_count);
    endtask

    // Offers one byte and returns the cycle number of the edge that accepted it.
    task automatic applyStimulus(input int inst, input logic [7:0] value, output longint t_acc);
        int guard = 0;
        if (inst == 0) begin a_valid = 1'b1; a_data = value; end
        else begin b_valid = 1'b1; b_data = value; end
        while (readyOf(inst) !== 1'b1 && guard < 5000) begin
            stepCycle();
            guard++;
        end
        t_acc = cyc + 1;
        stepCycle();
        if (inst == 0) a_valid = 1'b0; else b_valid = 1'b0;
        if (guard >= 5000) checkOutput("push_timeout", 64'(guard), 64'(0));
    endtask

    task automatic waitFrames(input int inst, input int n, input int budget, input string tag);
        int k = 0;
        while (rxCount(inst) < n && k < budget) begin
            stepCycle();
            k++;
        end
        checkOutput(tag, 64'(rxCount(inst)), 64'(n));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        longint     t, t1, t2;
        int         base, n, k, guard, starts_before, frames_before;
        bit         acc, low_seen;
        frame_t     f;
        logic [7:0] exp_q[$];

        // Reset state
        #0.5 resetn = 1'b0;
        repeat (3) stepCycle();
        checkOutput("rst_line", a_line, 1);
        checkOutput("rst_busy", a_busy, 0);
        checkOutput("rst_done", a_done, 0);
        checkOutput("rst_ready", a_ready, 0);
        checkOutput("rst_count", a_count, 0);
        checkOutput("rst_line_b", b_line, 1);
        resetn = 1'b1;
        stepCycle();
        checkOutput("ready_first_edge", a_ready, 1);
        checkOutput("ready_first_edge_b", b_ready, 1);

        // Single byte 0xA5: start 2 cycles after accept, done on cycle t+41
        $display("[TB] single byte");
        applyStimulus(0, 8'hA5, t);
        repeat (4) stepCycle();
        checkOutput("single_busy_mid", a_busy, 1);
        waitFrames(0, 1, 200, "single_frames");
        stepCycle();
        f = getFrame(0, 0);
        checkOutput("single_data", f.data, 8'hA5);
        checkOutput("single_framing", f.ok, 1);
        checkOutput("single_start", 64'(f.start_cyc), 64'(t + 2));
        checkOutput("single_done_n", 64'(done_a.size()), 64'(1));
        checkOutput("single_done_cyc", (done_a.size() > 0) ? 64'(done_a[0]) : 64'hx, 64'(t + 41));
        checkOutput("single_busy_after", a_busy, 0);

        // Back-to-back bytes pushed on consecutive cycles
        $display("[TB] back-to-back");
        base = rxCount(0);
        peak_a = 0;
        applyStimulus(0, 8'h00, t);
        applyStimulus(0, 8'hFF, t1);
        applyStimulus(0, 8'h3C, t2);
        waitFrames(0, base + 3, 400, "b2b_frames");
        checkOutput("b2b_peak", 64'(peak_a), 64'(2));
        for (int i = 0; i < 3; i++) begin
            logic [7:0] ev[3];
            ev[0] = 8'h00; ev[1] = 8'hFF; ev[2] = 8'h3C;
            f = getFrame(0, base + i);
            checkOutput($sformatf("b2b_data%0d", i), f.data, ev[i]);
            checkOutput($sformatf("b2b_ok%0d", i), f.ok, 1);
            checkOutput($sformatf("b2b_start%0d", i), 64'(f.start_cyc), 64'(t + 2 + 40 * i));
        end

        // Random bytes with random gaps; s_data scrambled while s_valid is low
        $display("[TB] random burst");
        base = rxCount(0);
        n = $urandom_range(4, 8);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            k = $urandom_range(0, 3);
            repeat (k) begin
                a_data = 8'($urandom);
                stepCycle();
            end
            exp_q.push_back(v);
            applyStimulus(0, v, t);
        end
        waitFrames(0, base + n, n * 45 + 200, "rand_frames");
        for (int i = 0; i < n; i++) begin
            f = getFrame(0, base + i);
            checkOutput($sformatf("rand_data%0d", i), f.data, exp_q[i]);
            checkOutput($sformatf("rand_ok%0d", i), f.ok, 1);
        end

        // Full and pointer wrap: 40 incrementing bytes with s_valid held high
        $display("[TB] full and wrap");
        base = rxCount(0);
        peak_a = 0;
        n = 0;
        guard = 0;
        a_valid = 1'b1;
        a_data = 8'd0;
        while (n < 40 && guard < 3000) begin
            acc = (a_ready === 1'b1);
            checkOutput("full_ready_rule", a_ready, (int'(a_count) != DEPTH) ? 1 : 0);
            stepCycle();
            guard++;
            if (acc) begin
                n++;
                a_data = 8'(n);
            end
        end
        a_valid = 1'b0;
        checkOutput("full_pushed", 64'(n), 64'(40));
        checkOutput("full_peak", 64'(peak_a), 64'(DEPTH));
        waitFrames(0, base + 40, 2000, "full_frames");
        for (int i = 0; i < 40; i++) begin
            f = getFrame(0, base + i);
            checkOutput($sformatf("full_data%0d", i), f.data, 8'(i));
        end

        // Reset during DATA bit 3 of 0xA5 with one more byte queued
        $display("[TB] reset mid-frame");
        applyStimulus(0, 8'hA5, t);
        applyStimulus(0, 8'h5A, t1);
        k = 0;
        while (cyc < t + 19 && k < 100) begin
            stepCycle();
            k++;
        end
        checkOutput("mid_pre_line", a_line, 0);
        checkOutput("mid_pre_busy", a_busy, 1);
        checkOutput("mid_pre_count", a_count, 1);
        #0.5 resetn = 1'b0;
        #0.2;
        checkOutput("mid_rst_line", a_line, 1);
        checkOutput("mid_rst_count", a_count, 0);
        checkOutput("mid_rst_busy", a_busy, 0);
        checkOutput("mid_rst_ready", a_ready, 0);
        repeat (2) stepCycle();
        starts_before = starts_a;
        frames_before = rxCount(0);
        resetn = 1'b1;
        stepCycle();
        checkOutput("mid_ready_first_edge", a_ready, 1);
        low_seen = 1'b0;
        repeat (100) begin
            stepCycle();
            if (a_line !== 1'b1) low_seen = 1'b1;
        end
        checkOutput("mid_no_residual_low", low_seen, 0);
        checkOutput("mid_no_new_start", 64'(starts_a), 64'(starts_before));
        checkOutput("mid_no_new_frame", 64'(rxCount(0)), 64'(frames_before));
        checkOutput("mid_count_after", a_count, 0);

        // Default rate: 1250 clocks (2500 ns) per bit, three back-to-back frames
        $display("[TB] default bit rate");
        exp_q.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h1F);
        exp_q.push_back(8'($urandom));
        applyStimulus(1, exp_q[0], t);
        applyStimulus(1, exp_q[1], t1);
        applyStimulus(1, exp_q[2], t2);
        waitFrames(1, 3, 40000, "def_frames");
        stepCycle();
        for (int i = 0; i < 3; i++) begin
            f = getFrame(1, i);
            checkOutput($sformatf("def_data%0d", i), f.data, exp_q[i]);
            checkOutput($sformatf("def_ok%0d", i), f.ok, 1);
            checkOutput($sformatf("def_start%0d", i), 64'(f.start_cyc), 64'(t + 2 + 10 * CPB_B * i));
        end
        checkOutput("def_frame_ns", 64'(longint'(getFrame(1, 1).start_t - getFrame(1, 0).start_t)), 64'(25000));
        checkOutput("def_done_last", (done_b.size() == 3) ? 64'(done_b[2]) : 64'hx, 64'(t + 1 + 30 * CPB_B));
        checkOutput("def_busy_after", b_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
